pe_param: RTL

Parametrised weight-stationary systolic processing element for the tiny-tpu array, generalising the 16-bit PE to arbitrary fixed-point width. It adds:
- row-tagged weight capture on the north weight chain
- a double-buffered weight register with an explicit shadow-full flag
- saturating fixed-point multiply-accumulate with a sticky overflow flag

---
 rtl/pe_param_if.sv | 79 +++++++
 rtl/pe_param.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pe_param_if.sv
// Bundle of every north/west input and south/east output of one pe_param instance.
// Latency: none (wires only); the registering happens inside pe_param.
// Backpressure: none; the systolic array advances every cycle, valid bits qualify data.
//
// Port summary:
//   inputs  : pe_psum_in, pe_weight_in/_valid_in/_tag_in, pe_input_in, pe_valid_in,
//             pe_switch_in, pe_sat_clear_in
//   outputs : pe_psum_out/_valid_out, pe_weight_out/_valid_out/_tag_out, pe_input_out,
//             pe_valid_out, pe_switch_out, pe_shadow_full, pe_sat_flag
//   modports: slave  = the PE itself (consumes *_in, produces *_out)
//             master = whoever drives the PE (neighbour PE, array edge or bench)
interface pe_param_if #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 4
);
    // north / west side
    logic [DATA_WIDTH-1:0] pe_psum_in;
    logic [DATA_WIDTH-1:0] pe_weight_in;
    logic                  pe_weight_valid_in;
    logic [TAG_WIDTH-1:0]  pe_weight_tag_in;
    logic [DATA_WIDTH-1:0] pe_input_in;
    logic                  pe_valid_in;
    logic                  pe_switch_in;
    logic                  pe_sat_clear_in;

    // south / east side and status
    logic [DATA_WIDTH-1:0] pe_psum_out;
    logic                  pe_psum_valid_out;
    logic [DATA_WIDTH-1:0] pe_weight_out;
    logic                  pe_weight_valid_out;
    logic [TAG_WIDTH-1:0]  pe_weight_tag_out;
    logic [DATA_WIDTH-1:0] pe_input_out;
    logic                  pe_valid_out;
    logic                  pe_switch_out;
    logic                  pe_shadow_full;
    logic                  pe_sat_flag;

    modport slave (
        input  pe_psum_in,
        input  pe_weight_in,
        input  pe_weight_valid_in,
        input  pe_weight_tag_in,
        input  pe_input_in,
        input  pe_valid_in,
        input  pe_switch_in,
        input  pe_sat_clear_in,
        output pe_psum_out,
        output pe_psum_valid_out,
        output pe_weight_out,
        output pe_weight_valid_out,
        output pe_weight_tag_out,
        output pe_input_out,
        output pe_valid_out,
        output pe_switch_out,
        output pe_shadow_full,
        output pe_sat_flag
    );

    modport master (
        output pe_psum_in,
        output pe_weight_in,
        output pe_weight_valid_in,
        output pe_weight_tag_in,
        output pe_input_in,
        output pe_valid_in,
        output pe_switch_in,
        output pe_sat_clear_in,
        input  pe_psum_out,
        input  pe_psum_valid_out,
        input  pe_weight_out,
        input  pe_weight_valid_out,
        input  pe_weight_tag_out,
        input  pe_input_out,
        input  pe_valid_out,
        input  pe_switch_out,
        input  pe_shadow_full,
        input  pe_sat_flag
    );
endinterface

// File: rtl/pe_param.sv
// Weight-stationary systolic PE: row-tagged double-buffered weight, saturating fixed-point MAC.
// Latency: every east/south output is registered, exactly 1 cycle after its input.
// Backpressure: none; data advances every cycle and valid bits mark the live beats.
//
// Port summary:
//   clk, rst : rising-edge clock, asynchronous active-high reset (released synchronously
//              by the surrounding reset tree)
//   pe       : pe_param_if.slave bundle -- psum/activation/control in from north/west,
//              psum south, activation/control east, weight chain north to south,
//              plus pe_shadow_full and the sticky pe_sat_flag status bits.
// The interface instance must be built with the same DATA_WIDTH/TAG_WIDTH as this module.
module pe_param #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int TAG_WIDTH  = 4,
    parameter int ROW_ID     = 0
) (
    input  logic       clk,
    input  logic       rst,
    pe_param_if.slave  pe
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [TAG_WIDTH-1:0]  ROW_TAG = TAG_WIDTH'(ROW_ID);

    // ------------------------------------------------------------------
    // Weight storage: active feeds the multiplier, shadow is loaded from
    // the north chain and promoted on a switch pulse.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] active_w;
    logic [DATA_WIDTH-1:0] shadow_w;
    logic                  shadow_full_q;
    logic                  sat_flag_q;

    logic                  capture;
    logic                  promote;

    // ------------------------------------------------------------------
    // MAC datapath
    // ------------------------------------------------------------------
    logic signed [PROD_WIDTH-1:0] product;
    logic signed [PROD_WIDTH-1:0] product_shr;
    logic [DATA_WIDTH:0]          prod_hi;
    logic                         prod_sat;
    logic [DATA_WIDTH-1:0]        prod_q;
    logic [DATA_WIDTH:0]          sum_ext;
    logic                         sum_sat;
    logic [DATA_WIDTH-1:0]        sum_q;
    logic                         mac_sat;

    assign capture = pe.pe_weight_valid_in && (pe.pe_weight_tag_in == ROW_TAG);
    // A switch with an empty shadow is a no-op for the active weight.
    assign promote = pe.pe_switch_in && shadow_full_q;

    always_comb begin
        // Both operands are sign-extended to the full product width before
        // multiplying so the product is exact.
        product     = PROD_WIDTH'($signed(pe.pe_input_in)) * PROD_WIDTH'($signed(active_w));
        // Arithmetic shift floors toward -inf, which is the rounding the
        // fixed-point format wants (no rounding bias correction).
        product_shr = product >>> FRAC_BITS;

        // The shifted product fits in DATA_WIDTH only if every bit from the
        // sign position of the narrow result upward is a copy of the MSB.
        prod_hi  = product_shr[PROD_WIDTH-1:DATA_WIDTH-1];
        prod_sat = !((&prod_hi) || (~|prod_hi));
        if (prod_sat) begin
            prod_q = product_shr[PROD_WIDTH-1] ? MIN_VAL : MAX_VAL;
        end else begin
            prod_q = product_shr[DATA_WIDTH-1:0];
        end

        // One guard bit is enough for the sum of two DATA_WIDTH values; the
        // result overflowed when the guard bit disagrees with the narrow MSB.
        sum_ext = {prod_q[DATA_WIDTH-1], prod_q} + {pe.pe_psum_in[DATA_WIDTH-1], pe.pe_psum_in};
        sum_sat = sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1];
        if (sum_sat) begin
            sum_q = sum_ext[DATA_WIDTH] ? MIN_VAL : MAX_VAL;
        end else begin
            sum_q = sum_ext[DATA_WIDTH-1:0];
        end

        mac_sat = prod_sat || sum_sat;
    end

    // ------------------------------------------------------------------
    // Weight chain forwarding: every weight continues south, captured or not.
    // Invalid beats are zeroed so idle lanes stay quiet.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe.pe_weight_out       <= '0;
            pe.pe_weight_valid_out <= 1'b0;
            pe.pe_weight_tag_out   <= '0;
        end else begin
            pe.pe_weight_valid_out <= pe.pe_weight_valid_in;
            pe.pe_weight_out       <= pe.pe_weight_valid_in ? pe.pe_weight_in : '0;
            pe.pe_weight_tag_out   <= pe.pe_weight_valid_in ? pe.pe_weight_tag_in : '0;
        end
    end

    // ------------------------------------------------------------------
    // Double buffer. Promotion reads the old shadow, so a simultaneous
    // capture lands in the shadow while the previous shadow becomes active,
    // and the shadow stays full.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_w      <= '0;
            shadow_w      <= '0;
            shadow_full_q <= 1'b0;
        end else begin
            if (promote) begin
                active_w <= shadow_w;
            end
            if (capture) begin
                shadow_w      <= pe.pe_weight_in;
                shadow_full_q <= 1'b1;
            end else if (promote) begin
                shadow_full_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // MAC result and activation/control forwarding. The multiplier sees the
    // active weight from before this edge, so a switch in the same cycle only
    // affects later beats.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe.pe_psum_out       <= '0;
            pe.pe_psum_valid_out <= 1'b0;
            pe.pe_input_out      <= '0;
            pe.pe_valid_out      <= 1'b0;
            pe.pe_switch_out     <= 1'b0;
        end else begin
            pe.pe_switch_out <= pe.pe_switch_in;
            if (pe.pe_valid_in) begin
                pe.pe_psum_out       <= sum_q;
                pe.pe_psum_valid_out <= 1'b1;
                pe.pe_input_out      <= pe.pe_input_in;
                pe.pe_valid_out      <= 1'b1;
            end else begin
                pe.pe_psum_out       <= '0;
                pe.pe_psum_valid_out <= 1'b0;
                pe.pe_input_out      <= '0;
                pe.pe_valid_out      <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky saturation flag. A saturation in the same cycle as a clear
    // keeps the flag set so the event is never lost.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag_q <= 1'b0;
        end else if (pe.pe_valid_in && mac_sat) begin
            sat_flag_q <= 1'b1;
        end else if (pe.pe_sat_clear_in) begin
            sat_flag_q <= 1'b0;
        end
    end

    assign pe.pe_shadow_full = shadow_full_q;
    assign pe.pe_sat_flag    = sat_flag_q;

endmodule
